// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Priority finder: lowest enabled channel overall (first=1) or lowest enabled channel above ch.
module scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] ch,
    input  logic             first,
    output logic [SEL_W-1:0] next_ch,
    output logic             has_next
);

    logic [N_CH-1:0] eligible;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_elig
            assign eligible[gi] = mask[gi] & (first | (SEL_W'(gi) > ch));
        end
    endgenerate

    // Walk downwards so the lowest eligible channel is the one left standing.
    always_comb begin
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                next_ch  = SEL_W'(i);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks enabled mux channels in ascending order, samples Y once per channel after a settle time, publishes a snapshot.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  mask,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  sample
);

    localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL);

    scan_state_t      state_reg, state_next;
    logic [SEL_W-1:0] ch_reg, ch_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N_CH-1:0]  mask_reg, mask_next;
    logic [N_CH-1:0]  shadow_reg, shadow_next;
    logic [N_CH-1:0]  sample_reg, sample_next;

    logic             find_first;
    logic [N_CH-1:0]  find_mask;
    logic [SEL_W-1:0] find_ch;
    logic             find_valid;

    // In IDLE the live mask seeds the first channel; afterwards only the latched copy matters.
    assign find_first = (state_reg == IDLE);
    assign find_mask  = find_first ? mask : mask_reg;

    scan_next_ch u_next_ch (
        .mask     (find_mask),
        .ch       (ch_reg),
        .first    (find_first),
        .next_ch  (find_ch),
        .has_next (find_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ch_reg     <= '0;
            cnt_reg    <= '0;
            mask_reg   <= '0;
            shadow_reg <= '0;
            sample_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            cnt_reg    <= cnt_next;
            mask_reg   <= mask_next;
            shadow_reg <= shadow_next;
            sample_reg <= sample_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        shadow_next = shadow_reg;
        sample_next = sample_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mask_next   = mask;
                    shadow_next = '0;
                    cnt_next    = '0;
                    if (find_valid) begin
                        state_next = SCAN;
                        ch_next    = find_ch;
                    end else begin
                        state_next  = DONE;
                        sample_next = '0;
                    end
                end
            end
            SCAN: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == DWELL_CNT) begin
                    shadow_next[ch_reg] = y_in;
                    cnt_next            = '0;
                    if (find_valid) begin
                        ch_next = find_ch;
                    end else begin
                        // Publish on entry to DONE, including the bit captured on this edge.
                        state_next  = DONE;
                        sample_next = shadow_next;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel    = ch_reg;
    assign en     = (state_reg == SCAN);
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign sample = sample_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: driver queues expected scans, a negedge monitor checks every cycle.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    localparam int D    = 2;
    localparam int SPAN = D + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en;
    logic       y_in;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic [3:0] in_vec;

    // Model of the 4:1 mux feeding the sequencer.
    assign y_in = in_vec[sel];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mask   (mask),
        .sel    (sel),
        .en     (en),
        .y_in   (y_in),
        .busy   (busy),
        .done   (done),
        .sample (sample)
    );

    typedef struct {
        int              t0;
        int              k;
        logic [3:0][1:0] chs;
        logic [3:0]      smp;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic       chk_on = 1'b0;
    logic       rst_at_edge = 1'b0;
    logic [3:0] hold = 4'b0000;

    exp_t       m_it;
    int         m_end;
    logic       m_en, m_busy, m_done;
    logic [1:0] m_sel;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (rst_at_edge) begin
                q.delete();
                hold = 4'b0000;
            end
            m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_sel = 2'd0;
            if (q.size() > 0) begin
                m_it  = q[0];
                m_end = m_it.t0 + m_it.k * SPAN;
                if (cyc >= m_it.t0 && cyc < m_end) begin
                    m_en   = 1'b1;
                    m_busy = 1'b1;
                    m_sel  = m_it.chs[(cyc - m_it.t0) / SPAN];
                end else if (cyc == m_end) begin
                    m_busy = 1'b1;
                    m_done = 1'b1;
                end
            end
            chk("en", en, m_en);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_en) chk("sel", sel, m_sel);
            if (m_done) begin
                chk("sample", sample, m_it.smp);
                hold = m_it.smp;
                void'(q.pop_front());
            end else begin
                chk("sample_hold", sample, hold);
            end
        end
    end

    task automatic issue(input logic [3:0] m, input logic [3:0] iv, output exp_t it);
        int k;
        @(negedge clk);
        in_vec = iv;
        mask   = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mask  = 4'($urandom);
        k = 0;
        it.chs = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                it.chs[k] = 2'(i);
                k++;
            end
        end
        it.t0  = cyc;
        it.k   = k;
        it.smp = m & iv;
        q.push_back(it);
        $display("scan t0=%0d mask=%b in=%b expect sample=%b done_at=%0d", it.t0, m, iv, it.smp, it.t0 + k * SPAN);
    endtask

    task automatic run_scan(input logic [3:0] m, input logic [3:0] iv, input bit dup);
        exp_t it;
        issue(m, iv, it);
        if (dup) begin
            @(negedge clk);
            if (it.k > 0) begin
                start = 1'b1;
                mask  = 4'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            while (cyc < it.t0 + it.k * SPAN) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int w = 0; w < 64 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            chk("scan_timeout", q.size(), 0);
            q.delete();
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        exp_t it;
        logic [3:0] rm, rv;
        rst    = 1'b1;
        start  = 1'b0;
        mask   = 4'b0000;
        in_vec = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_sel", sel, 0);

        run_scan(4'b1111, 4'b1010, 1'b1);
        run_scan(4'b0000, 4'b1111, 1'b1);
        run_scan(4'b0101, 4'b1111, 1'b1);

        // Reset once channel 1 has been sampled.
        issue(4'b1111, 4'b1111, it);
        while (cyc < it.t0 + 2 * SPAN) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sel", sel, 0);
        chk("rst_sample", sample, 0);
        repeat (4) @(negedge clk);
        $display("reset mid-scan at cycle %0d", cyc);

        run_scan(4'b1000, 4'b1000, 1'b0);
        for (int n = 0; n < 25; n++) begin
            rm = 4'($urandom);
            rv = 4'($urandom);
            run_scan(rm, rv, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
